// File: rtl/crypt_stream_feeder_if.sv
// crypt_stream_feeder_if: plaintext/result streams plus the accelerator register bus
interface crypt_stream_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] accel_addr;
  logic        accel_wr_en;
  logic        accel_select;
  logic [31:0] accel_wdata;
  logic [31:0] accel_rdata;
  modport master (
    input  in_valid, in_data, out_ready, accel_rdata,
    output in_ready, out_valid, out_data, accel_addr, accel_wr_en, accel_select, accel_wdata
  );
  modport slave (
    output in_valid, in_data, out_ready, accel_rdata,
    input  in_ready, out_valid, out_data, accel_addr, accel_wr_en, accel_select, accel_wdata
  );
endinterface

// File: rtl/crypt_stream_feeder.sv
// crypt_stream_feeder: writes plaintext blocks into the crypto accelerator, polls done, streams results out
module crypt_stream_feeder #(
  parameter int          WORDS    = 4,
  parameter logic [31:0] CTRL_OFF = 32'h00,
  parameter logic [31:0] PT_OFF   = 32'h08,
  parameter logic [31:0] CT_OFF   = 32'h10,
  parameter int          TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  crypt_stream_feeder_if.master        bus,
  input  logic                         err_clr_i,
  output logic                         busy_o,
  output logic                         timeout_err_o,
  output logic [15:0]                  block_cnt_o
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] GO   = 3'd2;
  localparam logic [2:0] POLL = 3'd3;
  localparam logic [2:0] RD   = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [15:0]   block_cnt_q, block_cnt_d;
  logic          err_q, err_d;
  logic          in_hs, out_hs, done, t_set;
  assign in_hs         = state_q == LOAD && bus.in_valid;
  assign out_hs        = state_q == OUT && bus.out_ready;
  assign done          = bus.accel_rdata[31];
  assign t_set         = state_q == POLL && !done && cnt_q == TLAST;
  assign bus.in_ready  = state_q == LOAD;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_data  = out_data_q;
  assign busy_o        = state_q != IDLE;
  assign timeout_err_o = err_q;
  assign block_cnt_o   = block_cnt_q;
  // accelerator bus: address and data are zero whenever the chip select is low
  always_comb begin
    bus.accel_select = in_hs || state_q == GO || state_q == POLL || state_q == RD;
    bus.accel_wr_en  = in_hs || state_q == GO;
    bus.accel_addr   = in_hs ? PT_OFF + 32'(idx_q) * 32'd4 :
                       (state_q == GO || state_q == POLL) ? CTRL_OFF :
                       state_q == RD ? CT_OFF + 32'(idx_q) * 32'd4 : 32'h0;
    bus.accel_wdata  = in_hs ? bus.in_data : state_q == GO ? 32'h1 : 32'h0;
  end
  // block sequencer; a new timeout wins over a coincident err_clr
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    block_cnt_d = block_cnt_q;
    err_d       = t_set || (err_q && !err_clr_i);
    case (state_q)
      IDLE: state_d = err_q ? IDLE : LOAD;
      LOAD: if (in_hs) begin
        idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
        state_d = idx_q == LAST ? GO : LOAD;
      end
      GO: begin
        state_d = POLL;
        cnt_d   = '0;
      end
      POLL: begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = '0;
        state_d = done ? RD : t_set ? IDLE : POLL;
      end
      RD: begin
        out_data_d = bus.accel_rdata;
        state_d    = OUT;
      end
      OUT: if (out_hs) begin
        idx_d       = idx_q == LAST ? '0 : idx_q + 1'b1;
        block_cnt_d = idx_q == LAST ? block_cnt_q + 16'd1 : block_cnt_q;
        state_d     = idx_q == LAST ? LOAD : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      block_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      block_cnt_q <= block_cnt_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_crypt_stream_feeder.sv
// tb_crypt_stream_feeder: accelerator model plus access/result scoreboards for crypt_stream_feeder
module tb_crypt_stream_feeder;
  localparam int W = 4;
  localparam int TMO = 16;
  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } acc_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        busy, terr;
  logic [15:0] bcnt;
  int          n_checks = 0;
  int          n_pass = 0;
  int          poll_cnt = 0;
  acc_t        acc_q[$];
  logic [31:0] out_q[$];
  logic        done_m = 1'b0;
  int          dly = 0;
  int          delay = 3;
  logic [31:0] ct_base = 32'hA0;
  crypt_stream_feeder_if bus();
  crypt_stream_feeder #(.WORDS(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clr_i(err_clr),
    .busy_o(busy), .timeout_err_o(terr), .block_cnt_o(bcnt)
  );
  always #5 clk = ~clk;
  // accelerator: GO clears done; done rises `delay` edges later (delay 0 = never)
  always @(posedge clk) begin
    if (bus.accel_select && bus.accel_wr_en && bus.accel_addr == 32'h0 && bus.accel_wdata[0]) begin
      done_m <= 1'b0;
      dly    <= delay;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) done_m <= 1'b1;
    end
  end
  assign bus.accel_rdata = bus.accel_addr == 32'h0 ? {done_m, 31'b0} : ct_base + ((bus.accel_addr - 32'h10) >> 2);
  // bus monitor: every non-poll access must match the scoreboard; idle bus must be all zero
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.accel_select) begin
        if (bus.accel_addr == 32'h0 && !bus.accel_wr_en) poll_cnt++;
        else begin
          n_checks++;
          if (acc_q.size() == 0)
            $display("FAIL acc_unexpected addr=%h wr=%b data=%h", bus.accel_addr, bus.accel_wr_en, bus.accel_wdata);
          else begin
            acc_t e;
            e = acc_q.pop_front();
            if (bus.accel_addr !== e.a || bus.accel_wr_en !== e.w || bus.accel_wdata !== e.d)
              $display("FAIL acc got addr=%h wr=%b data=%h want addr=%h wr=%b data=%h",
                       bus.accel_addr, bus.accel_wr_en, bus.accel_wdata, e.a, e.w, e.d);
            else n_pass++;
          end
        end
      end else begin
        n_checks++;
        if ({bus.accel_wr_en, bus.accel_addr, bus.accel_wdata} !== 65'h0)
          $display("FAIL idle_bus wr=%b addr=%h data=%h want 0", bus.accel_wr_en, bus.accel_addr, bus.accel_wdata);
        else n_pass++;
      end
    end
  end
  task automatic send_word(input logic [31:0] d, input int gap);
    bit ok = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL in_accept word=%h got in_ready=0 want 1", d);
    else n_pass++;
  endtask
  task automatic send_block(input logic [31:0] base, input int gap, input bit reads);
    poll_cnt = 0;
    for (int i = 0; i < W; i++) acc_q.push_back('{32'h08 + 32'(4 * i), 1'b1, base * 32'(i + 1)});
    acc_q.push_back('{32'h0, 1'b1, 32'h1});
    if (reads)
      for (int i = 0; i < W; i++) begin
        acc_q.push_back('{32'h10 + 32'(4 * i), 1'b0, 32'h0});
        out_q.push_back(ct_base + 32'(i));
      end
    for (int i = 0; i < W; i++) send_word(base * 32'(i + 1), gap);
  endtask
  task automatic recv_block(input int stall_idx, input int stall_len);
    logic [31:0] exp;
    bit ok;
    bus.out_ready = stall_idx != 0;
    for (int i = 0; i < W; i++) begin
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (bus.out_valid) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok) begin
        $display("FAIL out_wait word=%0d got out_valid=0 want 1", i);
        bus.out_ready = 1'b1;
        return;
      end
      n_pass++;
      exp = out_q.size() != 0 ? out_q[0] : 32'hDEAD_BEEF;
      if (i == stall_idx)
        for (int j = 0; j < stall_len; j++) begin
          n_checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== exp)
            $display("FAIL out_hold valid=%b data=%h want 1 %h", bus.out_valid, bus.out_data, exp);
          else n_pass++;
          @(posedge clk);
          #1 if (j == stall_len - 1) bus.out_ready = 1'b1;
          @(negedge clk);
        end
      if (out_q.size() != 0) void'(out_q.pop_front());
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp)
        $display("FAIL out_data word=%0d valid=%b data=%h want 1 %h", i, bus.out_valid, bus.out_data, exp);
      else n_pass++;
      @(posedge clk);
      #1 bus.out_ready = (i + 1) != stall_idx;
    end
    bus.out_ready = 1'b1;
  endtask
  task automatic test_reset;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.accel_select, busy, terr, bcnt} !== 52'h0)
      $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%h sel=%b busy=%b err=%b cnt=%h want 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.accel_select, busy, terr, bcnt);
    else n_pass++;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle in_ready=%b busy=%b want 0 0", bus.in_ready, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL reset_load in_ready=%b busy=%b want 1 1", bus.in_ready, busy);
    else n_pass++;
    #1 bus.in_valid = 1'b1;
    bus.in_data = 32'hCAFE_F00D;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.accel_select, bus.accel_wr_en, bus.accel_addr, bus.accel_wdata, busy, terr, bcnt} !== 117'h0)
      $display("FAIL reset_async in_ready=%b sel=%b wr=%b addr=%h busy=%b want 0", bus.in_ready, bus.accel_select, bus.accel_wr_en, bus.accel_addr, busy);
    else n_pass++;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_rerelease in_ready=%b want 1", bus.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_single_block;
    delay = 3;
    ct_base = 32'hA0;
    send_block(32'h1111_1111, 0, 1);
    recv_block(-1, 0);
    n_checks++;
    if (bcnt !== 16'd1 || poll_cnt != delay + 1) $display("FAIL single_block cnt=%h polls=%0d want 1 %0d", bcnt, poll_cnt, delay + 1);
    else n_pass++;
  endtask
  task automatic test_stale_done_stalls;
    n_checks++;
    if (done_m !== 1'b1) $display("FAIL stale_done_setup done=%b want 1", done_m);
    else n_pass++;
    delay = 2;
    ct_base = 32'hA0;
    send_block(32'h0102_0304, 1, 1);
    recv_block(1, 5);
    n_checks++;
    if (bcnt !== 16'd2 || poll_cnt != delay + 1) $display("FAIL stale_done cnt=%h polls=%0d want 2 %0d", bcnt, poll_cnt, delay + 1);
    else n_pass++;
  endtask
  task automatic test_timeout;
    bit seen = 0;
    delay = 0;
    send_block(32'h5555_5555, 0, 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (terr) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || poll_cnt != TMO) $display("FAIL timeout err=%b polls=%0d want 1 %0d", terr, poll_cnt, TMO);
    else n_pass++;
    repeat (4) begin
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bcnt !== 16'd2)
        $display("FAIL timeout_idle in_ready=%b out_valid=%b busy=%b cnt=%h want 0 0 0 2", bus.in_ready, bus.out_valid, busy, bcnt);
      else n_pass++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    n_checks++;
    if (terr !== 1'b0) $display("FAIL err_clr err=%b want 0", terr);
    else n_pass++;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL err_resume in_ready=%b want 1", bus.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_in_poll;
    delay = 0;
    send_block(32'h0909_0909, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.accel_select !== 1'b0 || bcnt !== 16'd0)
      $display("FAIL reset_poll busy=%b sel=%b cnt=%h want 0 0 0", busy, bus.accel_select, bcnt);
    else n_pass++;
    acc_q.delete();
    out_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    delay = 3;
    ct_base = 32'hA0;
    send_block(32'h1111_1111, 0, 1);
    recv_block(-1, 0);
    n_checks++;
    if (bcnt !== 16'd1) $display("FAIL rerun cnt=%h want 1", bcnt);
    else n_pass++;
  endtask
  task automatic test_wrap;
    force dut.block_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.block_cnt_q;
    n_checks++;
    if (bcnt !== 16'hFFFF) $display("FAIL wrap_setup cnt=%h want ffff", bcnt);
    else n_pass++;
    delay = 1;
    ct_base = 32'hB0;
    send_block(32'h0F0F_0F0F, 0, 1);
    recv_block(-1, 0);
    n_checks++;
    if (bcnt !== 16'h0000) $display("FAIL wrap cnt=%h want 0000", bcnt);
    else n_pass++;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    test_single_block();
    test_stale_done_stalls();
    test_timeout();
    test_reset_in_poll();
    test_wrap();
    repeat (3) @(posedge clk);
    n_checks++;
    if (acc_q.size() != 0 || out_q.size() != 0) $display("FAIL drain acc=%0d out=%0d want 0 0", acc_q.size(), out_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want finish before 200000", $time);
    $fatal(1, "watchdog");
  end
endmodule
